// File: rtl/axi_burst_mem_slv_pkg.sv
// Shared types for the AXI4 burst memory slave.
// Burst and response encodings, FSM state types and the response-severity
// merge used to fold per-beat responses into a single burst response.
package axi_slv_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } axi_burst_e;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [1:0] {
    WIdle,
    WData,
    WResp
  } wr_state_e;

  typedef enum logic {
    RIdle,
    RData
  } rd_state_e;

  // Severity happens to follow the encoding for the responses this slave
  // produces (OKAY < SLVERR < DECERR); EXOKAY is never generated.
  function automatic axi_resp_e resp_max(axi_resp_e a, axi_resp_e b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_burst_mem_slv_if.sv
// ID-less AXI4 bus bundle between a master and the burst memory slave.
// Ports: AW (awaddr, awlen, awburst, awvalid/awready), W (wdata, wstrb, wlast,
// wvalid/wready), B (bresp, bvalid/bready), AR (araddr, arlen, arburst,
// arvalid/arready), R (rdata, rresp, rlast, rvalid/rready).
// Modports: slave (memory side) and master (initiator side).
interface axi_burst_mem_slv_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;

  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;

  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport slave (
    input  awaddr, awlen, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arlen, arburst, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awaddr, awlen, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arlen, arburst, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready
  );

endinterface

// File: rtl/axi_burst_addr_gen.sv
// Per-beat address decode for one burst engine (purely combinational).
// Ports:
//   addr      in   byte address of the current beat
//   burst     in   AxBURST of the burst in flight
//   next_addr out  address of the following beat (INCR steps, others hold)
//   word      out  memory word index of addr
//   in_range  out  addr lies inside the backing memory
//   burst_err out  burst type is not supported (WRAP or reserved)
module axi_burst_addr_gen
  import axi_slv_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic [ADDR_W-1:0]            addr,
  input  logic [1:0]                   burst,
  output logic [ADDR_W-1:0]            next_addr,
  output logic [$clog2(MEM_WORDS)-1:0] word,
  output logic                         in_range,
  output logic                         burst_err
);

  localparam int unsigned AS = $clog2(DATA_W / 8);
  localparam int unsigned IW = $clog2(MEM_WORDS);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(DATA_W / 8);

  always_comb begin
    burst_err = (burst != FIXED) && (burst != INCR);
    next_addr = (burst == INCR) ? addr + STEP : addr;
    word      = addr[IW+AS-1:AS];
    // Anything above the memory's byte span decodes to nothing.
    in_range  = (addr[ADDR_W-1:IW+AS] == '0);
  end

endmodule

// File: rtl/axi_burst_mem_slv.sv
// AXI4 burst memory slave: independent write and read engines, one
// outstanding transaction each, over a DATA_W-wide word array.
// Ports:
//   aclk   in   clock, all logic on the rising edge
//   reset  in   synchronous active-high reset; abandons bursts in flight
//   bus    slave modport of axi_burst_mem_slv_if (AW, W, B, AR, R channels)
module axi_burst_mem_slv
  import axi_slv_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MEM_WORDS = 1024
) (
  input logic                  aclk,
  input logic                  reset,
  axi_burst_mem_slv_if.slave   bus
);

  localparam int unsigned IW = $clog2(MEM_WORDS);
  localparam int unsigned NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [MEM_WORDS];

  // ---------------------------------------------------------------- write
  wr_state_e         wr_state_q, wr_state_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [1:0]        wburst_q, wburst_d;
  logic [7:0]        wlen_q, wlen_d;
  logic [7:0]        wcnt_q, wcnt_d;
  logic              wovf_q, wovf_d;
  axi_resp_e         bresp_q, bresp_d;

  logic [ADDR_W-1:0] w_next;
  logic [IW-1:0]     w_word;
  logic              w_in_range, w_burst_err;
  axi_resp_e         w_beat_resp;
  logic              mem_we;

  axi_burst_addr_gen #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .MEM_WORDS (MEM_WORDS)
  ) u_wr_addr (
    .addr      (waddr_q),
    .burst     (wburst_q),
    .next_addr (w_next),
    .word      (w_word),
    .in_range  (w_in_range),
    .burst_err (w_burst_err)
  );

  always_comb begin
    wr_state_d  = wr_state_q;
    waddr_d     = waddr_q;
    wburst_d    = wburst_q;
    wlen_d      = wlen_q;
    wcnt_d      = wcnt_q;
    wovf_d      = wovf_q;
    bresp_d     = bresp_q;
    mem_we      = 1'b0;
    w_beat_resp = resp_max(w_burst_err ? SLVERR : OKAY, w_in_range ? OKAY : DECERR);

    unique case (wr_state_q)
      WIdle: begin
        if (bus.awvalid) begin
          waddr_d    = bus.awaddr;
          wburst_d   = bus.awburst;
          wlen_d     = bus.awlen;
          wcnt_d     = 8'd0;
          wovf_d     = 1'b0;
          bresp_d    = OKAY;
          wr_state_d = WData;
        end
      end
      WData: begin
        if (bus.wvalid) begin
          if (wovf_q) begin
            // Beats past awlen are swallowed until wlast and flag the burst.
            bresp_d = resp_max(bresp_q, SLVERR);
          end else begin
            mem_we  = !reset && (w_beat_resp == OKAY);
            bresp_d = resp_max(bresp_q, w_beat_resp);
            waddr_d = w_next;
            wcnt_d  = wcnt_q + 8'd1;
            if (!bus.wlast && (wcnt_q == wlen_q)) begin
              wovf_d = 1'b1;
            end
          end
          if (bus.wlast) begin
            wr_state_d = WResp;
          end
        end
      end
      WResp: begin
        if (bus.bready) begin
          wr_state_d = WIdle;
        end
      end
      default: wr_state_d = WIdle;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      wr_state_q <= WIdle;
      waddr_q    <= '0;
      wburst_q   <= 2'b00;
      wlen_q     <= 8'd0;
      wcnt_q     <= 8'd0;
      wovf_q     <= 1'b0;
      bresp_q    <= OKAY;
    end else begin
      wr_state_q <= wr_state_d;
      waddr_q    <= waddr_d;
      wburst_q   <= wburst_d;
      wlen_q     <= wlen_d;
      wcnt_q     <= wcnt_d;
      wovf_q     <= wovf_d;
      bresp_q    <= bresp_d;
    end
  end

  // Contents survive reset.
  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (bus.wstrb[b]) begin
          mem[w_word][b*8 +: 8] <= bus.wdata[b*8 +: 8];
        end
      end
    end
  end

  // ----------------------------------------------------------------- read
  rd_state_e         rd_state_q, rd_state_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;   // address of the next beat to load
  logic [1:0]        rburst_q, rburst_d;
  logic [7:0]        rlen_q, rlen_d;
  logic [7:0]        rcnt_q, rcnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  axi_resp_e         rresp_q, rresp_d;
  logic              rlast_q, rlast_d;

  logic [ADDR_W-1:0] r_addr, r_next;
  logic [1:0]        r_burst;
  logic [IW-1:0]     r_word;
  logic              r_in_range, r_burst_err;
  axi_resp_e         r_beat_resp;
  logic              r_load;

  // Beat 0 decodes straight from AR so it can be presented the next cycle.
  assign r_addr  = (rd_state_q == RIdle) ? bus.araddr  : raddr_q;
  assign r_burst = (rd_state_q == RIdle) ? bus.arburst : rburst_q;

  axi_burst_addr_gen #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .MEM_WORDS (MEM_WORDS)
  ) u_rd_addr (
    .addr      (r_addr),
    .burst     (r_burst),
    .next_addr (r_next),
    .word      (r_word),
    .in_range  (r_in_range),
    .burst_err (r_burst_err)
  );

  always_comb begin
    rd_state_d  = rd_state_q;
    raddr_d     = raddr_q;
    rburst_d    = rburst_q;
    rlen_d      = rlen_q;
    rcnt_d      = rcnt_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    rlast_d     = rlast_q;
    r_load      = 1'b0;
    r_beat_resp = resp_max(r_burst_err ? SLVERR : OKAY, r_in_range ? OKAY : DECERR);

    unique case (rd_state_q)
      RIdle: begin
        if (bus.arvalid) begin
          rburst_d   = bus.arburst;
          rlen_d     = bus.arlen;
          rcnt_d     = 8'd0;
          rlast_d    = (bus.arlen == 8'd0);
          r_load     = 1'b1;
          rd_state_d = RData;
        end
      end
      RData: begin
        if (bus.rready) begin
          if (rlast_q) begin
            rd_state_d = RIdle;
          end else begin
            r_load  = 1'b1;
            rcnt_d  = rcnt_q + 8'd1;
            rlast_d = ((rcnt_q + 8'd1) == rlen_q);
          end
        end
      end
    endcase

    // Registered load: a write to the same word on this edge is not seen.
    if (r_load) begin
      raddr_d = r_next;
      rresp_d = r_beat_resp;
      rdata_d = (r_beat_resp == OKAY) ? mem[r_word] : '0;
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      rd_state_q <= RIdle;
      raddr_q    <= '0;
      rburst_q   <= 2'b00;
      rlen_q     <= 8'd0;
      rcnt_q     <= 8'd0;
      rdata_q    <= '0;
      rresp_q    <= OKAY;
      rlast_q    <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      raddr_q    <= raddr_d;
      rburst_q   <= rburst_d;
      rlen_q     <= rlen_d;
      rcnt_q     <= rcnt_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      rlast_q    <= rlast_d;
    end
  end

  // -------------------------------------------------------------- outputs
  // Forced low while reset is held so an abandoned burst drops immediately.
  always_comb begin
    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    bus.bvalid  = 1'b0;
    bus.bresp   = 2'b00;
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    bus.rdata   = '0;
    bus.rresp   = 2'b00;
    bus.rlast   = 1'b0;
    if (!reset) begin
      bus.awready = (wr_state_q == WIdle);
      bus.wready  = (wr_state_q == WData);
      bus.bvalid  = (wr_state_q == WResp);
      bus.bresp   = bresp_q;
      bus.arready = (rd_state_q == RIdle);
      bus.rvalid  = (rd_state_q == RData);
      bus.rdata   = rdata_q;
      bus.rresp   = rresp_q;
      bus.rlast   = rlast_q;
    end
  end

endmodule
